// File: rtl/cpu_defs.sv
// Shared CPU definitions.
//   virt_t            : 32-bit virtual address
//   br_redir_state_e  : branch redirect controller FSM states
package cpu_defs;

  typedef logic [31:0] virt_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DS = 2'd1,
    REDIR   = 2'd2
  } br_redir_state_e;

  localparam virt_t TGT_RESET = 32'h0000_0000;

endpackage

// File: rtl/br_redirect_stats.sv
// Branch redirect statistics counters.
// Only instantiated when BR_REDIRECT_STATS_EN is defined.
//   clk, resetn  : clock, async active-low reset
//   accept       : a taken branch was accepted this cycle
//   in_wait_ds   : controller is waiting for the delay slot this cycle
//   taken_cnt    : number of accept cycles (wraps)
//   ds_wait_cnt  : number of cycles spent in WAIT_DS (wraps)
module br_redirect_stats (
  input  logic        clk,
  input  logic        resetn,
  input  logic        accept,
  input  logic        in_wait_ds,
  output logic [31:0] taken_cnt,
  output logic [31:0] ds_wait_cnt
);

  // Flush is intentionally not an input: the counters survive flushes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      taken_cnt   <= 32'd0;
      ds_wait_cnt <= 32'd0;
    end else begin
      if (accept)     taken_cnt   <= taken_cnt + 32'd1;
      if (in_wait_ds) ds_wait_cnt <= ds_wait_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/br_redirect_ctrl.sv
// Branch redirect controller: holds a resolved branch target until the
// delay slot has been fetched, then steers fetch to that target until the
// instruction memory accepts the request.
// Optional: BR_REDIRECT_STATS_EN adds taken_cnt / ds_wait_cnt outputs.
// Ports:
//   clk, resetn              : clock, async active-low reset
//   br_taken, br_stall       : branch resolution from ID
//   br_target                : resolved target PC
//   ds_to_es_fire            : branch leaves ID this cycle
//   fs_valid                 : IF holds an instruction (delay slot)
//   inst_req_ready           : instruction memory accepts the request
//   flush                    : exception/ERET flush from WB
//   redirect_valid           : fetch must use redirect_pc
//   redirect_pc              : held branch target
//   busy                     : FSM is not IDLE
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | no pending redirect
// WAIT_DS | target captured, delay slot not yet in IF
// REDIR   | delay slot fetched, presenting redirect to fetch
module br_redirect_ctrl
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        br_taken,
  input  logic        br_stall,
  input  virt_t       br_target,
  input  logic        ds_to_es_fire,
  input  logic        fs_valid,
  input  logic        inst_req_ready,
  input  logic        flush,
  output logic        redirect_valid,
  output virt_t       redirect_pc,
  output logic        busy
`ifdef BR_REDIRECT_STATS_EN
  ,
  output logic [31:0] taken_cnt,
  output logic [31:0] ds_wait_cnt
`endif
);

  br_redir_state_e state_q, state_d;
  virt_t           target_q;
  logic            accept;
  logic            capture;

  assign accept  = br_taken & ~br_stall & ds_to_es_fire & ~flush;
  // Accepts outside IDLE are dropped so the held target cannot move.
  assign capture = accept & (state_q == IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      target_q <= TGT_RESET;
    end else begin
      state_q <= state_d;
      if (capture) target_q <= br_target;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = fs_valid ? REDIR : WAIT_DS;
        WAIT_DS: if (fs_valid) state_d = REDIR;
        REDIR:   if (inst_req_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Flush masks the redirect in the same cycle it arrives.
  assign redirect_valid = (state_q == REDIR) & ~flush;
  assign redirect_pc    = target_q;
  assign busy           = (state_q != IDLE);

`ifdef BR_REDIRECT_STATS_EN
  br_redirect_stats u_stats (
    .clk         (clk),
    .resetn      (resetn),
    .accept      (accept),
    .in_wait_ds  (state_q == WAIT_DS),
    .taken_cnt   (taken_cnt),
    .ds_wait_cnt (ds_wait_cnt)
  );
`endif

endmodule

// File: tb/tb_br_redirect_ctrl.sv
module tb_br_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        br_taken, br_stall, ds_to_es_fire, fs_valid, inst_req_ready, flush;
  logic [31:0] br_target;
  logic        redirect_valid, busy;
  logic [31:0] redirect_pc;
`ifdef BR_REDIRECT_STATS_EN
  logic [31:0] taken_cnt, ds_wait_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a pending-redirect record rather than a state machine.
  bit          m_pending;  // a branch target is being held
  bit          m_ds_seen;  // delay slot has reached IF
  logic [31:0] m_tgt;
  logic [31:0] m_taken;
  logic [31:0] m_wait;

  always #5 clk = ~clk;

  br_redirect_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .br_taken       (br_taken),
    .br_stall       (br_stall),
    .br_target      (br_target),
    .ds_to_es_fire  (ds_to_es_fire),
    .fs_valid       (fs_valid),
    .inst_req_ready (inst_req_ready),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
`ifdef BR_REDIRECT_STATS_EN
    ,
    .taken_cnt      (taken_cnt),
    .ds_wait_cnt    (ds_wait_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 0;
    m_ds_seen = 0;
    m_tgt     = 32'h0;
    m_taken   = 32'h0;
    m_wait    = 32'h0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rv"},   {31'd0, redirect_valid}, {31'd0, m_pending & m_ds_seen & ~flush});
    chk({tag, ".pc"},   redirect_pc, m_tgt);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, m_pending});
`ifdef BR_REDIRECT_STATS_EN
    chk({tag, ".tcnt"}, taken_cnt, m_taken);
    chk({tag, ".wcnt"}, ds_wait_cnt, m_wait);
`endif
  endtask

  // One clock: drive after negedge, check mid-cycle, advance model at posedge.
  task automatic step(input logic t, input logic s, input logic [31:0] tg, input logic f,
                      input logic fv, input logic rdy, input logic fl, input string tag);
    bit acc;
    @(negedge clk);
    br_taken = t; br_stall = s; br_target = tg; ds_to_es_fire = f;
    fs_valid = fv; inst_req_ready = rdy; flush = fl;
    #1;
    check_outputs(tag);
    @(posedge clk);
    acc = t && !s && f && !fl;
    if (acc) m_taken = m_taken + 1;
    if (m_pending && !m_ds_seen) m_wait = m_wait + 1;
    if (fl) begin
      m_pending = 0;
    end else if (!m_pending) begin
      if (acc) begin
        m_pending = 1;
        m_ds_seen = fv;
        m_tgt     = tg;
      end
    end else if (!m_ds_seen) begin
      m_ds_seen = fv;
    end else if (rdy) begin
      m_pending = 0;
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 1, 1, 0, tag);
  endtask

  initial begin
    logic [31:0] w0;
    model_reset();
    resetn = 0;
    br_taken = 0; br_stall = 0; br_target = 32'h0; ds_to_es_fire = 0;
    fs_valid = 0; inst_req_ready = 0; flush = 0;
    #3;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    idle(2, "post_reset");

    // Accept with delay slot present, fetch ready immediately.
    step(1, 0, 32'hBFC0_0100, 1, 1, 1, 0, "dir1.acc");
    #1 chk("dir1.busy_after_acc", {31'd0, busy}, 32'd1);
    step(0, 0, 32'h0, 0, 1, 1, 0, "dir1.redir");
    #1 chk("dir1.back_idle", {31'd0, busy}, 32'd0);
    chk("dir1.pc", redirect_pc, 32'hBFC0_0100);
    idle(1, "dir1.idle");

    // Delay slot arrives 3 cycles late.
    w0 = m_wait;
    step(1, 0, 32'h8000_1000, 1, 0, 0, 0, "dir2.acc");
    for (int i = 0; i < 2; i++) step(0, 0, 32'h0, 0, 0, 0, 0, "dir2.wait");
    step(0, 0, 32'h0, 0, 1, 0, 0, "dir2.ds");
    chk("dir2.wait_cycles", m_wait - w0, 32'd3);
`ifdef BR_REDIRECT_STATS_EN
    #1 chk("dir2.ds_wait_delta", ds_wait_cnt - w0, 32'd3);
`endif
    // Held in REDIR while fetch is not ready for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'h0, 0, 1, 0, 0, "dir3.hold");
      #1 chk("dir3.pc_hold", redirect_pc, 32'h8000_1000);
    end
    step(0, 0, 32'h0, 0, 1, 1, 0, "dir3.ready");
    #1 chk("dir3.idle", {31'd0, busy}, 32'd0);

    // Flush in REDIR, and accept coincident with flush.
    step(1, 0, 32'h1234_5678, 1, 1, 0, 0, "dir4.acc");
    step(0, 0, 32'h0, 0, 1, 1, 1, "dir4.flush");
    step(1, 0, 32'hDEAD_BEE0, 1, 1, 1, 1, "dir4.acc_flush");
    idle(1, "dir4.idle");

    // Stalled branch is no event; second accept in REDIR is dropped.
    step(1, 1, 32'hAAAA_0000, 1, 1, 0, 0, "dir5.stall");
    chk("dir5.no_capture", redirect_pc, 32'h1234_5678);
    step(1, 0, 32'h5555_0000, 1, 1, 0, 0, "dir5.acc");
    step(1, 0, 32'h6666_0000, 1, 1, 0, 0, "dir5.acc2");
    #1 chk("dir5.tgt_kept", redirect_pc, 32'h5555_0000);
    step(0, 0, 32'h0, 0, 1, 1, 0, "dir5.ready");

    // Reset mid-WAIT_DS.
    step(1, 0, 32'h9000_0040, 1, 0, 0, 0, "dir6.acc");
    step(0, 0, 32'h0, 0, 0, 0, 0, "dir6.wait");
    #2 resetn = 0;
    model_reset();
    #1 check_outputs("dir6.in_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 0, 1, 1, 0, "dir6.after");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom,
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/br_redirect_ctrl.md
BR_REDIRECT_CTRL -- requirements
Module: br_redirect_ctrl

Interface
REQ-001 SHALL have port clk  in  1  sole clock, rising edge.
REQ-002 SHALL have port resetn  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port br_taken  in  1  resolved branch/jump taken in ID.
REQ-004 SHALL have port br_stall  in  1  branch operands not ready; ignore br_taken this cycle.
REQ-005 SHALL have port br_target  in  32 (virt_t)  resolved target PC.
REQ-006 SHALL have port ds_to_es_fire  in  1  branch instruction leaves ID this cycle.
REQ-007 SHALL have port fs_valid  in  1  IF holds an instruction (the delay slot when behind a branch).
REQ-008 SHALL have port inst_req_ready  in  1  instruction memory accepts the fetch request (addr_ok).
REQ-009 SHALL have port flush  in  1  exception/ERET flush from WB.
REQ-010 SHALL have port redirect_valid  out  1  fetch must use redirect_pc as next PC.
REQ-011 SHALL have port redirect_pc  out  32 (virt_t)  held branch target.
REQ-012 SHALL have port busy  out  1  state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_DS, REDIR.
REQ-014 SHALL define accept = br_taken & ~br_stall & ds_to_es_fire & ~flush.
REQ-015 SHALL, in IDLE on accept, capture br_target into the target register on that edge.
REQ-016 SHALL, in IDLE on accept, go to REDIR if fs_valid=1, else to WAIT_DS.
REQ-017 SHALL, in WAIT_DS, hold until fs_valid=1, then go to REDIR next edge.
REQ-018 SHALL drive redirect_valid=1 only in REDIR with flush=0; redirect_pc = target register.
REQ-019 SHALL, in REDIR, return to IDLE on the edge where inst_req_ready=1.
REQ-020 SHALL hold redirect_pc stable while redirect_valid=1 and inst_req_ready=0.
REQ-021 SHALL ignore accept outside IDLE; the target register SHALL NOT change.
REQ-022 SHALL, when flush=1 in any state, mask redirect_valid combinationally that cycle and enter IDLE next edge.
REQ-023 SHALL give flush priority over accept, fs_valid and inst_req_ready in the same cycle.
REQ-024 SHALL take minimum latency accept->redirect_valid of 1 cycle; REDIR->IDLE of 1 cycle after inst_req_ready.
REQ-025 SHALL treat br_stall=1 with br_taken=1 as no event; no state change.
REQ-026 SHALL drive busy=1 in WAIT_DS and REDIR.

Reset
REQ-027 SHALL, on resetn=0, asynchronously force state IDLE, target register 0x00000000.
REQ-028 SHALL hold redirect_valid=0, redirect_pc=0x00000000 and busy=0 while in reset.
REQ-029 SHALL discard a pending redirect when reset asserts mid-operation; no redirect after release.

Configuration
REQ-030 SHALL, with BR_REDIRECT_STATS_EN defined, add outputs taken_cnt (32) and ds_wait_cnt (32).
REQ-031 taken_cnt SHALL increment by 1 per accept; ds_wait_cnt SHALL increment per cycle in WAIT_DS; both wrap 0xFFFFFFFF->0.
REQ-032 SHALL reset both counters to 0 asynchronously; flush SHALL NOT clear them.
REQ-033 SHALL, without BR_REDIRECT_STATS_EN, omit the counter ports and logic entirely.

Structure
REQ-034 SHALL place the state enum br_redir_state_e in the shared cpu_defs package, reusing virt_t there.
REQ-035 SHALL keep the FSM and target register in this module.
REQ-036 SHALL implement the counters in one sub-module br_redirect_stats, instantiated only under the macro.

Verification
REQ-037 SHALL cover: fs_valid=1, accept target 0xBFC00100, inst_req_ready=1 -> redirect_valid for one cycle, pc 0xBFC00100, then IDLE.
REQ-038 SHALL cover: fs_valid=0 for 3 cycles after accept (0x80001000) -> WAIT_DS 3 cycles, REDIR after fs_valid; ds_wait_cnt=3 with macro.
REQ-039 SHALL cover: REDIR with inst_req_ready=0 for 4 cycles -> redirect_pc held 0x80001000 throughout, IDLE after ready.
REQ-040 SHALL cover: flush=1 in REDIR -> redirect_valid=0 same cycle, IDLE next edge; accept with flush -> ignored.
REQ-041 SHALL cover: br_taken=1, br_stall=1 -> no capture; second accept in REDIR -> target unchanged.
REQ-042 SHALL cover: resetn low mid-WAIT_DS -> outputs 0 immediately, no redirect after release.
